// File: rtl/mips16_pipeline_regs.sv
// rtl/mips16_pipeline_regs.sv - IF/ID, ID/EX and EX/MEM stage registers of the 16-bit MIPS-style core
//
// Ports:
//   clk, rst            rising-edge clock; asynchronous active-high reset
//   IF/ID   in : ifid_en, flush, instr_if, pc_if
//           out: instr_id, pc_id
//   ID/EX   in : idex_en, decoded control (memtoreg .. aluop), decoded data (pc_plus2 .. rd)
//           out: the same fields suffixed _ex
//   EX/MEM  in : EX-stage copies of the control bits (ex_memtoreg .. ex_mem_write),
//                zero, pc_branch_ex, alu_out_ex, reg_b_fwd, dst_ex
//           out: memtoreg_m .. ld_en_m, pcsrc, pc_branch_m, alu_out_m, reg_b_m, dst_m
//
// The EX-stage control inputs carry an ex_ prefix because the plain *_ex names
// are already taken by the ID/EX outputs that normally drive them.

module mips16_pipeline_regs (
  input  logic        clk,
  input  logic        rst,

  // IF/ID
  input  logic        ifid_en,
  input  logic        flush,
  input  logic [15:0] instr_if,
  input  logic [15:0] pc_if,
  output logic [15:0] instr_id,
  output logic [15:0] pc_id,

  // ID/EX control
  input  logic        idex_en,
  input  logic        memtoreg,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        reg_dst,
  input  logic        alusrc_a,
  input  logic        branch,
  input  logic        jump,
  input  logic        halt,
  input  logic        word_en,
  input  logic        ld_en,
  input  logic [1:0]  alusrc_b,
  input  logic [2:0]  aluop,

  // ID/EX data
  input  logic [15:0] pc_plus2,
  input  logic [15:0] reg_a,
  input  logic [15:0] reg_b,
  input  logic [15:0] sign_extended,
  input  logic [5:0]  branch_label,
  input  logic [11:0] jump_addr,
  input  logic [2:0]  rs,
  input  logic [2:0]  rt,
  input  logic [2:0]  rd,

  output logic        memtoreg_ex,
  output logic        reg_write_ex,
  output logic        mem_read_ex,
  output logic        mem_write_ex,
  output logic        reg_dst_ex,
  output logic        alusrc_a_ex,
  output logic        branch_ex,
  output logic        jump_ex,
  output logic        halt_ex,
  output logic        word_en_ex,
  output logic        ld_en_ex,
  output logic [1:0]  alusrc_b_ex,
  output logic [2:0]  aluop_ex,

  output logic [15:0] pc_plus2_ex,
  output logic [15:0] reg_a_ex,
  output logic [15:0] reg_b_ex,
  output logic [15:0] sign_extended_ex,
  output logic [5:0]  branch_label_ex,
  output logic [11:0] jump_addr_ex,
  output logic [2:0]  rs_ex,
  output logic [2:0]  rt_ex,
  output logic [2:0]  rd_ex,

  // EX/MEM
  input  logic        ex_memtoreg,
  input  logic        ex_reg_write,
  input  logic        ex_branch,
  input  logic        ex_jump,
  input  logic        ex_halt,
  input  logic        ex_word_en,
  input  logic        ex_ld_en,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        zero,
  input  logic [15:0] pc_branch_ex,
  input  logic [15:0] alu_out_ex,
  input  logic [15:0] reg_b_fwd,
  input  logic [2:0]  dst_ex,

  output logic        memtoreg_m,
  output logic        reg_write_m,
  output logic        pcsrc,
  output logic        jump_m,
  output logic        mem_read_m,
  output logic        mem_write_m,
  output logic        halt_m,
  output logic        word_en_m,
  output logic        ld_en_m,
  output logic [15:0] pc_branch_m,
  output logic [15:0] alu_out_m,
  output logic [15:0] reg_b_m,
  output logic [2:0]  dst_m
);

  // IF/ID: flush beats stall so a taken branch always kills the wrong-path fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_id <= 16'h0000;
      pc_id    <= 16'h0000;
    end else if (flush) begin
      instr_id <= 16'h0000;   // all-zero encoding is the NOP
      pc_id    <= 16'h0000;
    end else if (ifid_en) begin
      instr_id <= instr_if;
      pc_id    <= pc_if;
    end
  end

  // ID/EX data: loads every edge; a bubble is made harmless by its controls alone.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_plus2_ex      <= 16'h0000;
      reg_a_ex         <= 16'h0000;
      reg_b_ex         <= 16'h0000;
      sign_extended_ex <= 16'h0000;
      branch_label_ex  <= 6'd0;
      jump_addr_ex     <= 12'd0;
      rs_ex            <= 3'd0;
      rt_ex            <= 3'd0;
      rd_ex            <= 3'd0;
    end else begin
      pc_plus2_ex      <= pc_plus2;
      reg_a_ex         <= reg_a;
      reg_b_ex         <= reg_b;
      sign_extended_ex <= sign_extended;
      branch_label_ex  <= branch_label;
      jump_addr_ex     <= jump_addr;
      rs_ex            <= rs;
      rt_ex            <= rt;
      rd_ex            <= rd;
    end
  end

  // ID/EX control: idex_en low clears every field, giving a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst || !idex_en) begin
      memtoreg_ex  <= 1'b0;
      reg_write_ex <= 1'b0;
      mem_read_ex  <= 1'b0;
      mem_write_ex <= 1'b0;
      reg_dst_ex   <= 1'b0;
      alusrc_a_ex  <= 1'b0;
      branch_ex    <= 1'b0;
      jump_ex      <= 1'b0;
      halt_ex      <= 1'b0;
      word_en_ex   <= 1'b0;
      ld_en_ex     <= 1'b0;
      alusrc_b_ex  <= 2'd0;
      aluop_ex     <= 3'd0;
    end else begin
      memtoreg_ex  <= memtoreg;
      reg_write_ex <= reg_write;
      mem_read_ex  <= mem_read;
      mem_write_ex <= mem_write;
      reg_dst_ex   <= reg_dst;
      alusrc_a_ex  <= alusrc_a;
      branch_ex    <= branch;
      jump_ex      <= jump;
      halt_ex      <= halt;
      word_en_ex   <= word_en;
      ld_en_ex     <= ld_en;
      alusrc_b_ex  <= alusrc_b;
      aluop_ex     <= aluop;
    end
  end

  // EX/MEM: unconditional; the branch decision is folded into pcsrc here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memtoreg_m  <= 1'b0;
      reg_write_m <= 1'b0;
      pcsrc       <= 1'b0;
      jump_m      <= 1'b0;
      mem_read_m  <= 1'b0;
      mem_write_m <= 1'b0;
      halt_m      <= 1'b0;
      word_en_m   <= 1'b0;
      ld_en_m     <= 1'b0;
      pc_branch_m <= 16'h0000;
      alu_out_m   <= 16'h0000;
      reg_b_m     <= 16'h0000;
      dst_m       <= 3'd0;
    end else begin
      memtoreg_m  <= ex_memtoreg;
      reg_write_m <= ex_reg_write;
      pcsrc       <= ex_branch & zero;
      jump_m      <= ex_jump;
      mem_read_m  <= ex_mem_read;
      mem_write_m <= ex_mem_write;
      halt_m      <= ex_halt;
      word_en_m   <= ex_word_en;
      ld_en_m     <= ex_ld_en;
      pc_branch_m <= pc_branch_ex;
      alu_out_m   <= alu_out_ex;
      reg_b_m     <= reg_b_fwd;   // store data after forwarding
      dst_m       <= dst_ex;
    end
  end

endmodule

// File: tb/tb_mips16_pipeline_regs.sv
// tb/tb_mips16_pipeline_regs.sv - scoreboard bench for mips16_pipeline_regs
module tb_mips16_pipeline_regs;

  logic        clk, rst;
  logic        ifid_en, flush, idex_en;
  logic [15:0] instr_if, pc_if;
  logic [15:0] instr_id, pc_id;
  logic        memtoreg, reg_write, mem_read, mem_write, reg_dst, alusrc_a;
  logic        branch, jump, halt, word_en, ld_en;
  logic [1:0]  alusrc_b;
  logic [2:0]  aluop;
  logic [15:0] pc_plus2, reg_a, reg_b, sign_extended;
  logic [5:0]  branch_label;
  logic [11:0] jump_addr;
  logic [2:0]  rs, rt, rd;
  logic        memtoreg_ex, reg_write_ex, mem_read_ex, mem_write_ex, reg_dst_ex, alusrc_a_ex;
  logic        branch_ex, jump_ex, halt_ex, word_en_ex, ld_en_ex;
  logic [1:0]  alusrc_b_ex;
  logic [2:0]  aluop_ex;
  logic [15:0] pc_plus2_ex, reg_a_ex, reg_b_ex, sign_extended_ex;
  logic [5:0]  branch_label_ex;
  logic [11:0] jump_addr_ex;
  logic [2:0]  rs_ex, rt_ex, rd_ex;
  logic        ex_memtoreg, ex_reg_write, ex_branch, ex_jump, ex_halt;
  logic        ex_word_en, ex_ld_en, ex_mem_read, ex_mem_write, zero;
  logic [15:0] pc_branch_ex, alu_out_ex, reg_b_fwd;
  logic [2:0]  dst_ex;
  logic        memtoreg_m, reg_write_m, pcsrc, jump_m, mem_read_m, mem_write_m;
  logic        halt_m, word_en_m, ld_en_m;
  logic [15:0] pc_branch_m, alu_out_m, reg_b_m;
  logic [2:0]  dst_m;

  mips16_pipeline_regs dut (
    .clk(clk), .rst(rst),
    .ifid_en(ifid_en), .flush(flush), .instr_if(instr_if), .pc_if(pc_if),
    .instr_id(instr_id), .pc_id(pc_id),
    .idex_en(idex_en),
    .memtoreg(memtoreg), .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_dst(reg_dst), .alusrc_a(alusrc_a), .branch(branch), .jump(jump), .halt(halt),
    .word_en(word_en), .ld_en(ld_en), .alusrc_b(alusrc_b), .aluop(aluop),
    .pc_plus2(pc_plus2), .reg_a(reg_a), .reg_b(reg_b), .sign_extended(sign_extended),
    .branch_label(branch_label), .jump_addr(jump_addr), .rs(rs), .rt(rt), .rd(rd),
    .memtoreg_ex(memtoreg_ex), .reg_write_ex(reg_write_ex), .mem_read_ex(mem_read_ex),
    .mem_write_ex(mem_write_ex), .reg_dst_ex(reg_dst_ex), .alusrc_a_ex(alusrc_a_ex),
    .branch_ex(branch_ex), .jump_ex(jump_ex), .halt_ex(halt_ex), .word_en_ex(word_en_ex),
    .ld_en_ex(ld_en_ex), .alusrc_b_ex(alusrc_b_ex), .aluop_ex(aluop_ex),
    .pc_plus2_ex(pc_plus2_ex), .reg_a_ex(reg_a_ex), .reg_b_ex(reg_b_ex),
    .sign_extended_ex(sign_extended_ex), .branch_label_ex(branch_label_ex),
    .jump_addr_ex(jump_addr_ex), .rs_ex(rs_ex), .rt_ex(rt_ex), .rd_ex(rd_ex),
    .ex_memtoreg(ex_memtoreg), .ex_reg_write(ex_reg_write), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_halt(ex_halt), .ex_word_en(ex_word_en), .ex_ld_en(ex_ld_en),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .zero(zero),
    .pc_branch_ex(pc_branch_ex), .alu_out_ex(alu_out_ex), .reg_b_fwd(reg_b_fwd), .dst_ex(dst_ex),
    .memtoreg_m(memtoreg_m), .reg_write_m(reg_write_m), .pcsrc(pcsrc), .jump_m(jump_m),
    .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .halt_m(halt_m),
    .word_en_m(word_en_m), .ld_en_m(ld_en_m), .pc_branch_m(pc_branch_m),
    .alu_out_m(alu_out_m), .reg_b_m(reg_b_m), .dst_m(dst_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam int S_INSTR_ID = 0, S_PC_ID = 1, S_CTRL_EX = 2, S_REG_A_EX = 3, S_RW_EX = 4,
                 S_RW_M = 5, S_PCSRC = 6, S_PC_BR_M = 7, S_ALU_M = 8, S_REG_B_M = 9,
                 S_DST_M = 10, S_JUMP_M = 11, S_ANY_OUT = 12;

  typedef struct {
    string       tag;
    int          sig;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;

  function automatic logic [15:0] observe(int s);
    case (s)
      S_INSTR_ID: return instr_id;
      S_PC_ID:    return pc_id;
      S_CTRL_EX:  return {memtoreg_ex, reg_write_ex, mem_read_ex, mem_write_ex, reg_dst_ex,
                          alusrc_a_ex, branch_ex, jump_ex, halt_ex, word_en_ex, ld_en_ex,
                          alusrc_b_ex, aluop_ex};
      S_REG_A_EX: return reg_a_ex;
      S_RW_EX:    return {15'd0, reg_write_ex};
      S_RW_M:     return {15'd0, reg_write_m};
      S_PCSRC:    return {15'd0, pcsrc};
      S_PC_BR_M:  return pc_branch_m;
      S_ALU_M:    return alu_out_m;
      S_REG_B_M:  return reg_b_m;
      S_DST_M:    return {13'd0, dst_m};
      S_JUMP_M:   return {15'd0, jump_m};
      default:    return {15'd0, (|{instr_id, pc_id, memtoreg_ex, reg_write_ex, mem_read_ex,
                     mem_write_ex, reg_dst_ex, alusrc_a_ex, branch_ex, jump_ex, halt_ex,
                     word_en_ex, ld_en_ex, alusrc_b_ex, aluop_ex, pc_plus2_ex, reg_a_ex,
                     reg_b_ex, sign_extended_ex, branch_label_ex, jump_addr_ex, rs_ex, rt_ex,
                     rd_ex, memtoreg_m, reg_write_m, pcsrc, jump_m, mem_read_m, mem_write_m,
                     halt_m, word_en_m, ld_en_m, pc_branch_m, alu_out_m, reg_b_m, dst_m})};
    endcase
  endfunction

  task automatic push_exp(input string tag, input int sig, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [15:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = observe(e.sig);
      tests_run++;
      assert (o === e.val) else begin
        tests_failed++;
        $error("FAIL %s: observed 0x%04h expected 0x%04h", e.tag, o, e.val);
      end
    end
  endtask

  // Advance one rising edge and check everything expected of it, sampling 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic set_ctrl(input logic [15:0] v);
    {memtoreg, reg_write, mem_read, mem_write, reg_dst, alusrc_a, branch, jump, halt,
     word_en, ld_en, alusrc_b, aluop} = v;
  endtask

  initial begin
    rst = 1'b1;
    ifid_en = 1'b0; flush = 1'b0; idex_en = 1'b0;
    instr_if = 16'h0; pc_if = 16'h0;
    set_ctrl(16'h0);
    pc_plus2 = 16'h0; reg_a = 16'h0; reg_b = 16'h0; sign_extended = 16'h0;
    branch_label = 6'd0; jump_addr = 12'd0; rs = 3'd0; rt = 3'd0; rd = 3'd0;
    {ex_memtoreg, ex_reg_write, ex_branch, ex_jump, ex_halt,
     ex_word_en, ex_ld_en, ex_mem_read, ex_mem_write, zero} = 10'd0;
    pc_branch_ex = 16'h0; alu_out_ex = 16'h0; reg_b_fwd = 16'h0; dst_ex = 3'd0;

    push_exp("reset_initial", S_ANY_OUT, 16'd0);
    step();
    rst = 1'b0;

    // Fill every stage with non-zero state
    ifid_en = 1'b1; idex_en = 1'b1;
    instr_if = 16'h1111; pc_if = 16'h0003;
    set_ctrl(16'hFFFF); reg_a = 16'h1234;
    ex_reg_write = 1'b1; alu_out_ex = 16'h4321;
    push_exp("pre_reset_state", S_ANY_OUT, 16'd1);
    step();

    // Asynchronous reset in mid-cycle
    #3 rst = 1'b1;
    #1 push_exp("async_reset_midcycle", S_ANY_OUT, 16'd0);
    drain();
    push_exp("reset_held_over_edge", S_ANY_OUT, 16'd0);
    step();
    rst = 1'b0;
    set_ctrl(16'h0); reg_a = 16'h0; ex_reg_write = 1'b0; alu_out_ex = 16'h0;
    instr_if = 16'h1234; pc_if = 16'h0005;
    push_exp("post_reset_instr", S_INSTR_ID, 16'h1234);
    push_exp("post_reset_pc", S_PC_ID, 16'h0005);
    step();

    // Pipeline flow
    for (int k = 1; k <= 3; k++) begin
      instr_if = 16'hA000 + 16'(k);
      pc_if = 16'(2 * k);
      push_exp($sformatf("flow_instr_%0d", k), S_INSTR_ID, 16'hA000 + 16'(k));
      push_exp($sformatf("flow_pc_%0d", k), S_PC_ID, 16'(2 * k));
      step();
    end
    reg_write = 1'b1;
    push_exp("flow_reg_write_ex", S_RW_EX, 16'd1);
    push_exp("flow_reg_write_m_before", S_RW_M, 16'd0);
    step();
    reg_write = 1'b0; ex_reg_write = 1'b1;
    push_exp("flow_reg_write_ex_drop", S_RW_EX, 16'd0);
    push_exp("flow_reg_write_m", S_RW_M, 16'd1);
    step();
    ex_reg_write = 1'b0;

    // Stall plus bubble
    instr_if = 16'h5AC3; pc_if = 16'h0020;
    push_exp("stall_setup", S_INSTR_ID, 16'h5AC3);
    step();
    ifid_en = 1'b0; idex_en = 1'b0;
    instr_if = 16'h9999; pc_if = 16'h0099;
    set_ctrl(16'hFFFF); reg_a = 16'h00FF;
    push_exp("stall_hold_instr", S_INSTR_ID, 16'h5AC3);
    push_exp("stall_hold_pc", S_PC_ID, 16'h0020);
    push_exp("bubble_ctrl_zero", S_CTRL_EX, 16'h0000);
    push_exp("bubble_reg_a_loads", S_REG_A_EX, 16'h00FF);
    step();
    idex_en = 1'b1;
    set_ctrl(16'hA5C3); reg_a = 16'h0F0F;
    push_exp("reenter_ctrl", S_CTRL_EX, 16'hA5C3);
    push_exp("reenter_reg_a", S_REG_A_EX, 16'h0F0F);
    push_exp("reenter_still_held", S_INSTR_ID, 16'h5AC3);
    step();
    set_ctrl(16'hFFFF);
    push_exp("ctrl_all_ones", S_CTRL_EX, 16'hFFFF);
    step();

    // Flush priority
    flush = 1'b1; ifid_en = 1'b0; instr_if = 16'h7777; pc_if = 16'h0033;
    push_exp("flush_stall_instr", S_INSTR_ID, 16'h0000);
    push_exp("flush_stall_pc", S_PC_ID, 16'h0000);
    step();
    ifid_en = 1'b1; instr_if = 16'h1357;
    step();
    flush = 1'b0;
    push_exp("flush_with_en_instr", S_INSTR_ID, 16'h0000);
    drain();
    push_exp("after_flush_load", S_INSTR_ID, 16'h1357);
    step();

    // Branch decision
    ex_branch = 1'b1; zero = 1'b1; pc_branch_ex = 16'h0010;
    push_exp("branch_taken_pcsrc", S_PCSRC, 16'd1);
    push_exp("branch_target", S_PC_BR_M, 16'h0010);
    step();
    zero = 1'b0;
    push_exp("branch_not_zero", S_PCSRC, 16'd0);
    step();
    ex_branch = 1'b0; zero = 1'b1;
    push_exp("zero_without_branch", S_PCSRC, 16'd0);
    step();
    zero = 1'b0;

    // EX results into MEM
    alu_out_ex = 16'hBEEF; reg_b_fwd = 16'h0042; dst_ex = 3'd5; ex_jump = 1'b1;
    push_exp("fwd_alu_out", S_ALU_M, 16'hBEEF);
    push_exp("fwd_reg_b", S_REG_B_M, 16'h0042);
    push_exp("fwd_dst", S_DST_M, 16'd5);
    push_exp("fwd_jump", S_JUMP_M, 16'd1);
    step();
    ex_jump = 1'b0; alu_out_ex = 16'h1001;
    push_exp("jump_clears", S_JUMP_M, 16'd0);
    push_exp("alu_out_next", S_ALU_M, 16'h1001);
    step();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
